// File: rtl/frv_fairness_pkg.sv
// Shared types and constants for the memory-handshake fairness monitor.
package frv_fairness_pkg;
  typedef enum logic {FAIR_IDLE, FAIR_WAIT} fair_state_t;
  localparam int TXN_W = 8;
endpackage

// File: rtl/frv_fairness_chan.sv
// One req/gnt channel: wait FSM, field capture, stall/txn counters, sticky flags.
// FRV_FAIRNESS_ASSUME_EN adds formal assume/assert properties for this channel.
module frv_fairness_chan import frv_fairness_pkg::*; #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_STALL = 4,
  parameter int CW        = $clog2(MAX_STALL+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             wen,
  input  logic [DW/8-1:0]  strb,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  input  logic             gnt,
  input  logic             err,
  output logic             stall_viol,
  output logic             stab_viol,
  output logic             err_viol,
  output logic [CW-1:0]    stall_cnt,
  output logic [TXN_W-1:0] txn_cnt
);
  fair_state_t state, state_nxt;
  logic            cap_wen;
  logic [DW/8-1:0] cap_strb;
  logic [AW-1:0]   cap_addr;
  logic [DW-1:0]   cap_wdata;
  logic stall, done, changed, at_max, cap_en, stab_hit;

  assign stall  = req & ~gnt;
  assign done   = req & gnt;
  assign at_max = (stall_cnt == CW'(MAX_STALL));
  // Write payload only matters when the waiting request is a write.
  assign changed = (wen != cap_wen) | (addr != cap_addr) |
                   (cap_wen & ((strb != cap_strb) | (wdata != cap_wdata)));

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    stab_hit  = 1'b0;
    case (state)
      FAIR_IDLE: begin
        if (stall) begin
          state_nxt = FAIR_WAIT;
          cap_en    = 1'b1;
        end
      end
      FAIR_WAIT: begin
        if (!req) begin
          stab_hit  = 1'b1;
          state_nxt = FAIR_IDLE;
        end else begin
          stab_hit = changed;
          if (gnt) state_nxt = FAIR_IDLE;
        end
      end
      default: state_nxt = FAIR_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FAIR_IDLE;
      cap_wen    <= 1'b0;
      cap_strb   <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      stall_cnt  <= '0;
      txn_cnt    <= '0;
      stall_viol <= 1'b0;
      stab_viol  <= 1'b0;
      err_viol   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap_en) begin
        cap_wen   <= wen;
        cap_strb  <= strb;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end
      if (stall) stall_cnt <= at_max ? stall_cnt : stall_cnt + CW'(1);
      else       stall_cnt <= '0;
      if (stall && at_max) stall_viol <= 1'b1;
      if (stab_hit)        stab_viol  <= 1'b1;
      if (err && !gnt)     err_viol   <= 1'b1;
      if (done)            txn_cnt    <= txn_cnt + TXN_W'(1);
    end
  end

`ifdef FRV_FAIRNESS_ASSUME_EN
  // Latency and error legality belong to the environment; stability to the DUT.
  asm_latency: assume property (@(posedge clock) disable iff (reset) !(stall && at_max));
  asm_err:     assume property (@(posedge clock) disable iff (reset) !(err && !gnt));
  ast_stab:    assert property (@(posedge clock) disable iff (reset) 1'b1 |=> !stab_viol);
`endif
endmodule

// File: rtl/frv_mem_fairness.sv
// Multi-channel req/gnt fairness monitor; one frv_fairness_chan per channel.
// Define FRV_FAIRNESS_ASSUME_EN to emit formal assume/assert properties.
module frv_mem_fairness import frv_fairness_pkg::*; #(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_STALL = 4,
  parameter int CW        = $clog2(MAX_STALL+1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         wen,
  input  logic [NCH*(DW/8)-1:0]  strb,
  input  logic [NCH*AW-1:0]      addr,
  input  logic [NCH*DW-1:0]      wdata,
  input  logic [NCH-1:0]         gnt,
  input  logic [NCH-1:0]         err,
  output logic [NCH-1:0]         stall_viol,
  output logic [NCH-1:0]         stab_viol,
  output logic [NCH-1:0]         err_viol,
  output logic [NCH*CW-1:0]      stall_cnt,
  output logic [NCH*TXN_W-1:0]   txn_cnt
);
  localparam int SW = DW/8;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    frv_fairness_chan #(
      .AW(AW), .DW(DW), .MAX_STALL(MAX_STALL), .CW(CW)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .req        (req[i]),
      .wen        (wen[i]),
      .strb       (strb[i*SW +: SW]),
      .addr       (addr[i*AW +: AW]),
      .wdata      (wdata[i*DW +: DW]),
      .gnt        (gnt[i]),
      .err        (err[i]),
      .stall_viol (stall_viol[i]),
      .stab_viol  (stab_viol[i]),
      .err_viol   (err_viol[i]),
      .stall_cnt  (stall_cnt[i*CW +: CW]),
      .txn_cnt    (txn_cnt[i*TXN_W +: TXN_W])
    );
  end
endmodule

// File: tb/tb_frv_mem_fairness.sv
// Directed table-driven bench for frv_mem_fairness (NCH=2, MAX_STALL=4).
module tb_frv_mem_fairness;
  localparam int NCH = 2, AW = 32, DW = 32, MS = 4, CW = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic [NCH-1:0]     req, wen, gnt, err;
  logic [NCH*DW/8-1:0] strb;
  logic [NCH*AW-1:0]  addr;
  logic [NCH*DW-1:0]  wdata;
  logic [NCH-1:0]     stall_viol, stab_viol, err_viol;
  logic [NCH*CW-1:0]  stall_cnt;
  logic [NCH*8-1:0]   txn_cnt;

  frv_mem_fairness #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_STALL(MS)) dut (
    .clock(clock), .reset(reset), .req(req), .wen(wen), .strb(strb),
    .addr(addr), .wdata(wdata), .gnt(gnt), .err(err),
    .stall_viol(stall_viol), .stab_viol(stab_viol), .err_viol(err_viol),
    .stall_cnt(stall_cnt), .txn_cnt(txn_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [1:0] req, wen, gnt, err;
    logic [31:0] a1, d1;
    logic [1:0] sv, tv, ev;
    logic [5:0] sc;
    logic [7:0] t0, t1;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  task automatic add(input logic rst, input logic [1:0] rq, input logic [1:0] we,
                     input logic [1:0] gn, input logic [1:0] er,
                     input logic [31:0] a1, input logic [31:0] d1,
                     input logic [1:0] sv, input logic [1:0] tv, input logic [1:0] ev,
                     input logic [5:0] sc, input logic [7:0] t0, input logic [7:0] t1);
    vec_t v;
    v.rst = rst; v.req = rq; v.wen = we; v.gnt = gn; v.err = er;
    v.a1 = a1; v.d1 = d1; v.sv = sv; v.tv = tv; v.ev = ev;
    v.sc = sc; v.t0 = t0; v.t1 = t1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive on the falling edge, then sample just after the rising edge.
  task automatic drive(input logic rst, input logic [1:0] rq, input logic [1:0] we,
                       input logic [1:0] gn, input logic [1:0] er,
                       input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clock);
    reset = rst; req = rq; wen = we; gnt = gn; err = er;
    addr  = {a1, 32'h0000_0040};
    wdata = {d1, 32'h0};
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] sv, input logic [1:0] tv,
                           input logic [1:0] ev, input logic [5:0] sc,
                           input logic [7:0] t0, input logic [7:0] t1);
    check({tag, ".flags"}, {58'b0, stall_viol, stab_viol, err_viol}, {58'b0, sv, tv, ev});
    check({tag, ".stall_cnt"}, {58'b0, stall_cnt}, {58'b0, sc});
    check({tag, ".txn_cnt"}, {48'b0, txn_cnt}, {48'b0, t1, t0});
  endtask

  initial begin
    reset = 1'b1; req = '0; wen = '0; gnt = '0; err = '0;
    strb = '1; addr = '0; wdata = '0;

    // rst req wen gnt err a1 d1 | sv tv ev sc t0 t1 ; sc = {ch1,ch0}
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    // ch0 grant on 5th cycle: legal
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd1, 0, 0);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd2, 0, 0);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd3, 0, 0);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd4, 0, 0);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 6'd0, 1, 0);
    // ch0 five stalled cycles: violation, count saturates
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd1, 1, 0);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd2, 1, 0);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd3, 1, 0);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd4, 1, 0);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 6'd4, 1, 0);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 2'b01, 0, 0, 6'd0, 2, 0);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    // ch1 address change while waiting
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 32'h100, 0, 0, 0, 0, 6'd8, 0, 0);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 32'h104, 0, 0, 2'b10, 0, 6'd16, 0, 0);
    add(0, 2'b10, 2'b00, 2'b10, 2'b00, 32'h104, 0, 0, 2'b10, 0, 6'd0, 0, 1);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    // ch1 read: wdata changes ignored
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 32'h200, 32'hAAAA, 0, 0, 0, 6'd8, 0, 0);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 32'h200, 32'h5555, 0, 0, 0, 6'd16, 0, 0);
    add(0, 2'b10, 2'b00, 2'b10, 2'b00, 32'h200, 32'h1234, 0, 0, 0, 6'd0, 0, 1);
    // ch1 write: wdata change in the grant cycle is flagged
    add(0, 2'b10, 2'b10, 2'b00, 2'b00, 32'h200, 32'h1, 0, 0, 0, 6'd8, 0, 1);
    add(0, 2'b10, 2'b10, 2'b10, 2'b00, 32'h200, 32'h2, 0, 2'b10, 0, 6'd0, 0, 2);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    // ch0 err with grant is fine, err without grant is flagged
    add(0, 2'b01, 2'b00, 2'b01, 2'b01, 0, 0, 0, 0, 0, 6'd0, 1, 0);
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 2'b01, 6'd0, 1, 0);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd0, 0, 0);
    // ch0 drops req while waiting
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd1, 0, 0);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b01, 0, 6'd0, 0, 0);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 6'd0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].wen, vecs[i].gnt, vecs[i].err,
            vecs[i].a1, vecs[i].d1);
      check_all($sformatf("vec%0d", i), vecs[i].sv, vecs[i].tv, vecs[i].ev,
                vecs[i].sc, vecs[i].t0, vecs[i].t1);
    end

    // 300 zero-latency grants on ch1 wrap the 8-bit counter to 44
    for (int n = 0; n < 300; n++) drive(0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    check_all("wrap300", 2'b00, 2'b00, 2'b00, 6'd0, 8'd0, 8'd44);

    // reset during a 3-cycle stall abandons the wait
    for (int n = 0; n < 3; n++) drive(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
    check_all("stall3", 2'b00, 2'b00, 2'b00, 6'd3, 8'd0, 8'd44);
    drive(1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
    check_all("midrst", 2'b00, 2'b00, 2'b00, 6'd0, 8'd0, 8'd0);
    // req low now would be a drop if the FSM were still waiting
    drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    check_all("idle_after_rst", 2'b00, 2'b00, 2'b00, 6'd0, 8'd0, 8'd0);
    drive(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
    check_all("fresh_req", 2'b00, 2'b00, 2'b00, 6'd1, 8'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
